// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl
//   Machine-mode performance counter block behind a simple CSR request port.
//   Counters: C0 mcycle, C2 minstret, C3/C4 mhpmcounter3/4 (selectable events),
//   with mcountinhibit, mhpmevent3/4 selectors and sticky overflow flags.
//   Each CSR access runs IDLE -> EXEC -> RESP: accepted in IDLE, evaluated in
//   EXEC (read sampled, write committed on the EXEC exit edge), answered in RESP.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   clk_en            global advance; FSM, counters and flags hold when 0
//   ev_retire         one instruction retired this cycle
//   ev_vec            raw event pulses, selected by mhpmevent3/4 (1-based)
//   csr_req/we/addr/wdata  request; accepted when csr_ready & clk_en
//   csr_ready         high only in IDLE
//   csr_rvalid        high only in RESP, with csr_rdata / csr_err
//
// PERF_CNT_LEN is expected to be in 33..64 so the hi half maps to [63:32].
module perf_counter_ctrl #(
  parameter int unsigned PERF_CNT_LEN = 64,
  parameter int unsigned NUM_EVENTS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  ev_retire,
  input  logic [NUM_EVENTS-1:0] ev_vec,
  input  logic                  csr_req,
  input  logic                  csr_we,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic                  csr_ready,
  output logic                  csr_rvalid,
  output logic [31:0]           csr_rdata,
  output logic                  csr_err
);

  // Internal counter index: 0 = C0, 1 = C2, 2 = C3, 3 = C4.
  // inh/ovf bit i corresponds to CSR bit {0,2,3,4}[i].
  localparam int unsigned NCNT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  logic        req_we_q;
  logic [11:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [PERF_CNT_LEN-1:0] cnt_q [NCNT];
  logic [PERF_CNT_LEN-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]         inh_q, inh_d;
  logic [NCNT-1:0]         ovf_q, ovf_d, ovf_set, w1c_mask;
  logic [NCNT-1:0]         ev_hit;
  logic [3:0]              sel_q [2];
  logic [3:0]              sel_d [2];

  // Decoded view of the latched request
  logic        dec_err;
  logic        dec_cnt;
  logic [1:0]  dec_cnt_idx;
  logic        dec_hi;
  logic        dec_mirror;
  logic        dec_inh;
  logic        dec_sel;
  logic        dec_sel_idx;
  logic        dec_ovf;
  logic [31:0] dec_rdata;
  logic [63:0] cnt_view;
  logic [63:0] cnt_wr_val;
  logic        wr_ok;

  // True when sel is 1..NUM_EVENTS and the matching event line is high.
  function automatic logic sel_match(input logic [3:0] sel,
                                     input logic [NUM_EVENTS-1:0] ev);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
      if (32'(sel) == k + 1 && ev[k]) hit = 1'b1;
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    csr_ready  = 1'b0;
    csr_rvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        csr_ready = 1'b1;
        if (csr_req && clk_en) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: if (clk_en) state_d = RESP;
      RESP: begin
        csr_rvalid = 1'b1;
        if (clk_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    csr_rdata = csr_rvalid ? rdata_q : '0;
    csr_err   = csr_rvalid & err_q;
  end

  // ---------------------------------------------------------- decode
  always_comb begin
    dec_err     = 1'b0;
    dec_cnt     = 1'b0;
    dec_cnt_idx = 2'd0;
    dec_hi      = 1'b0;
    dec_mirror  = 1'b0;
    dec_inh     = 1'b0;
    dec_sel     = 1'b0;
    dec_sel_idx = 1'b0;
    dec_ovf     = 1'b0;
    unique case (req_addr_q)
      12'hB00: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd0; end
      12'hB80: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd0; dec_hi = 1'b1; end
      12'hB02: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd1; end
      12'hB82: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd1; dec_hi = 1'b1; end
      12'hB03: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd2; end
      12'hB83: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd2; dec_hi = 1'b1; end
      12'hB04: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd3; end
      12'hB84: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd3; dec_hi = 1'b1; end
      12'hC00: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd0; dec_mirror = 1'b1; end
      12'hC80: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd0; dec_mirror = 1'b1; dec_hi = 1'b1; end
      12'hC02: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd1; dec_mirror = 1'b1; end
      12'hC82: begin dec_cnt = 1'b1; dec_cnt_idx = 2'd1; dec_mirror = 1'b1; dec_hi = 1'b1; end
      12'h320: dec_inh = 1'b1;
      12'h323: begin dec_sel = 1'b1; dec_sel_idx = 1'b0; end
      12'h324: begin dec_sel = 1'b1; dec_sel_idx = 1'b1; end
      12'h7C0: dec_ovf = 1'b1;
      default: dec_err = 1'b1;
    endcase
    if (dec_mirror && req_we_q) dec_err = 1'b1;
  end

  always_comb begin
    cnt_view  = 64'(cnt_q[dec_cnt_idx]);
    dec_rdata = '0;
    if (dec_cnt)      dec_rdata = dec_hi ? cnt_view[63:32] : cnt_view[31:0];
    else if (dec_inh) dec_rdata = {27'd0, inh_q[3], inh_q[2], inh_q[1], 1'b0, inh_q[0]};
    else if (dec_sel) dec_rdata = {28'd0, sel_q[dec_sel_idx]};
    else if (dec_ovf) dec_rdata = {27'd0, ovf_q[3], ovf_q[2], ovf_q[1], 1'b0, ovf_q[0]};
    cnt_wr_val = dec_hi ? {req_wdata_q, cnt_view[31:0]} : {cnt_view[63:32], req_wdata_q};
  end

  // Writes commit on the edge that leaves EXEC.
  assign wr_ok = (state_q == EXEC) && clk_en && req_we_q && !dec_err;

  // ------------------------------------------------- next-state values
  always_comb begin
    ev_hit[0] = 1'b1;
    ev_hit[1] = ev_retire;
    ev_hit[2] = sel_match(sel_q[0], ev_vec);
    ev_hit[3] = sel_match(sel_q[1], ev_vec);
    ovf_set   = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      // A CSR write to the counter suppresses that cycle's increment (and
      // therefore any overflow it would have produced).
      if (wr_ok && dec_cnt && 32'(dec_cnt_idx) == i) begin
        cnt_d[i] = cnt_wr_val[PERF_CNT_LEN-1:0];
      end else if (clk_en && !inh_q[i] && ev_hit[i]) begin
        cnt_d[i]   = cnt_q[i] + PERF_CNT_LEN'(1);
        ovf_set[i] = &cnt_q[i];
      end
    end

    w1c_mask = (wr_ok && dec_ovf) ?
               {req_wdata_q[4], req_wdata_q[3], req_wdata_q[2], req_wdata_q[0]} : '0;
    // New overflow takes priority over a simultaneous W1C clear.
    ovf_d = (ovf_q & ~w1c_mask) | ovf_set;

    inh_d = (wr_ok && dec_inh) ?
            {req_wdata_q[4], req_wdata_q[3], req_wdata_q[2], req_wdata_q[0]} : inh_q;

    sel_d[0] = sel_q[0];
    sel_d[1] = sel_q[1];
    if (wr_ok && dec_sel) sel_d[dec_sel_idx] = req_wdata_q[3:0];
  end

  // ------------------------------------------------------ state regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      inh_q    <= '0;
      ovf_q    <= '0;
      sel_q[0] <= '0;
      sel_q[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      inh_q    <= inh_d;
      ovf_q    <= ovf_d;
      sel_q[0] <= sel_d[0];
      sel_q[1] <= sel_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        req_we_q    <= csr_we;
        req_addr_q  <= csr_addr;
        req_wdata_q <= csr_wdata;
      end
      if (state_q == EXEC && clk_en) begin
        err_q   <= dec_err;
        rdata_q <= (req_we_q || dec_err) ? '0 : dec_rdata;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
module tb_perf_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        ev_retire;
  logic [7:0]  ev_vec;
  logic        csr_req;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_ready;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        csr_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  perf_counter_ctrl #(.PERF_CNT_LEN(64), .NUM_EVENTS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .ev_retire (ev_retire),
    .ev_vec    (ev_vec),
    .csr_req   (csr_req),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_ready (csr_ready),
    .csr_rvalid(csr_rvalid),
    .csr_rdata (csr_rdata),
    .csr_err   (csr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: every response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && csr_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h err %0b, expected no response",
                 csr_rdata, csr_err);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".rdata"}, csr_rdata, e.rdata);
        check({nm, ".err"}, 32'(csr_err), 32'(e.err));
      end
    end
  end

  // Issue one access at a negedge; returns at the negedge after RESP.
  task automatic csr_xfer(input string nm, input bit we, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input bit exp_err);
    exp_t e;
    int   lat;
    int   guard;
    guard = 0;
    while (!csr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!csr_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.ready_wait: got ready 0, expected 1 within 20 cycles", nm);
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
    csr_req   = 1'b1;
    csr_we    = we;
    csr_addr  = addr;
    csr_wdata = wdata;
    lat = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) csr_req = 1'b0;
    end while (!csr_rvalid && lat < 10);
    check({nm, ".latency"}, 32'(lat), 32'd2);
    ev_retire = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] v, input int n);
    repeat (n) begin
      ev_vec = v;
      @(negedge clk);
      ev_vec = '0;
      @(negedge clk);
    end
  endtask

  task automatic retire(input int n);
    repeat (n) begin
      ev_retire = 1'b1;
      @(negedge clk);
      ev_retire = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    ev_retire = 1'b0;
    ev_vec    = '0;
    csr_req   = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst.ready",  32'(csr_ready),  32'd1);
    check("rst.rvalid", 32'(csr_rvalid), 32'd0);
    check("rst.rdata",  csr_rdata,       32'd0);
    check("rst.err",    32'(csr_err),    32'd0);

    // 10 counted edges, then the acceptance edge: EXEC sees 11
    clk_en = 1'b1;
    rst_n  = 1'b1;
    repeat (10) @(negedge clk);
    csr_xfer("mcycle_first", 1'b0, 12'hB00, 32'd0, 32'd11, 1'b0);
    csr_xfer("mcycle_mirror", 1'b0, 12'hC00, 32'd0, 32'd14, 1'b0);
    csr_xfer("mcycle_hi", 1'b0, 12'hB80, 32'd0, 32'd0, 1'b0);

    // Event selection on C3
    csr_xfer("wr_ev3_3", 1'b1, 12'h323, 32'd3, 32'd0, 1'b0);
    csr_xfer("rd_ev3", 1'b0, 12'h323, 32'd0, 32'd3, 1'b0);
    pulse(8'h04, 5);
    pulse(8'h01, 4);
    csr_xfer("c3_sel3", 1'b0, 12'hB03, 32'd0, 32'd5, 1'b0);
    csr_xfer("c4_idle", 1'b0, 12'hB04, 32'd0, 32'd0, 1'b0);
    csr_xfer("wr_ev3_upper", 1'b1, 12'h323, 32'hFFFF_FFF0, 32'd0, 1'b0);
    csr_xfer("rd_ev3_zero", 1'b0, 12'h323, 32'd0, 32'd0, 1'b0);
    pulse(8'h04, 3);
    csr_xfer("c3_sel0_frozen", 1'b0, 12'hB03, 32'd0, 32'd5, 1'b0);
    csr_xfer("wr_ev3_9", 1'b1, 12'h323, 32'd9, 32'd0, 1'b0);
    pulse(8'hFF, 2);
    csr_xfer("c3_sel9_frozen", 1'b0, 12'hB03, 32'd0, 32'd5, 1'b0);
    csr_xfer("wr_ev3_8", 1'b1, 12'h323, 32'd8, 32'd0, 1'b0);
    pulse(8'h80, 1);
    csr_xfer("c3_sel8", 1'b0, 12'hB03, 32'd0, 32'd6, 1'b0);

    // Overflow of C3 and W1C
    csr_xfer("wr_c3_hi", 1'b1, 12'hB83, 32'hFFFF_FFFF, 32'd0, 1'b0);
    csr_xfer("wr_c3_lo", 1'b1, 12'hB03, 32'hFFFF_FFFE, 32'd0, 1'b0);
    csr_xfer("wr_ev3_1", 1'b1, 12'h323, 32'd1, 32'd0, 1'b0);
    csr_xfer("c3_lo_pre", 1'b0, 12'hB03, 32'd0, 32'hFFFF_FFFE, 1'b0);
    csr_xfer("c3_hi_pre", 1'b0, 12'hB83, 32'd0, 32'hFFFF_FFFF, 1'b0);
    pulse(8'h01, 2);
    csr_xfer("c3_wrapped_lo", 1'b0, 12'hB03, 32'd0, 32'd0, 1'b0);
    csr_xfer("c3_wrapped_hi", 1'b0, 12'hB83, 32'd0, 32'd0, 1'b0);
    csr_xfer("ovf_set", 1'b0, 12'h7C0, 32'd0, 32'h8, 1'b0);
    csr_xfer("ovf_w1c", 1'b1, 12'h7C0, 32'h8, 32'd0, 1'b0);
    csr_xfer("ovf_cleared", 1'b0, 12'h7C0, 32'd0, 32'd0, 1'b0);

    // C4 selector
    csr_xfer("wr_ev4_2", 1'b1, 12'h324, 32'd2, 32'd0, 1'b0);
    pulse(8'h02, 2);
    csr_xfer("c4_sel2", 1'b0, 12'hB04, 32'd0, 32'd2, 1'b0);
    csr_xfer("rd_ev4", 1'b0, 12'h324, 32'd0, 32'd2, 1'b0);

    // Inhibit and write-wins
    csr_xfer("wr_inh", 1'b1, 12'h320, 32'hFFFF_FFE1, 32'd0, 1'b0);
    csr_xfer("rd_inh", 1'b0, 12'h320, 32'd0, 32'h1, 1'b0);
    csr_xfer("wr_c0", 1'b1, 12'hB00, 32'h55, 32'd0, 1'b0);
    csr_xfer("c0_held", 1'b0, 12'hB00, 32'd0, 32'h55, 1'b0);
    csr_xfer("c0_held_mirror", 1'b0, 12'hC00, 32'd0, 32'h55, 1'b0);
    ev_retire = 1'b1;   // active through the write; cleared by the task after RESP
    csr_xfer("wr_c2_busy", 1'b1, 12'hB02, 32'h55, 32'd0, 1'b0);
    csr_xfer("c2_write_wins", 1'b0, 12'hB02, 32'd0, 32'h55, 1'b0);
    retire(3);
    csr_xfer("c2_retire3", 1'b0, 12'hC02, 32'd0, 32'h58, 1'b0);
    csr_xfer("wr_inh_c2", 1'b1, 12'h320, 32'h5, 32'd0, 1'b0);
    retire(2);
    csr_xfer("c2_inhibited", 1'b0, 12'hB02, 32'd0, 32'h58, 1'b0);
    csr_xfer("rd_inh_5", 1'b0, 12'h320, 32'd0, 32'h5, 1'b0);

    // Illegal accesses
    csr_xfer("wr_mirror", 1'b1, 12'hC00, 32'h1234, 32'd0, 1'b1);
    csr_xfer("c0_after_err", 1'b0, 12'hB00, 32'd0, 32'h55, 1'b0);
    csr_xfer("rd_unmapped", 1'b0, 12'h7FF, 32'd0, 32'd0, 1'b1);
    csr_xfer("rd_b01", 1'b0, 12'hB01, 32'd0, 32'd0, 1'b1);
    csr_xfer("wr_unmapped", 1'b1, 12'h7C1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    csr_xfer("ovf_after_err", 1'b0, 12'h7C0, 32'd0, 32'd0, 1'b0);

    // Reset during EXEC of a write to C2: aborted, no response
    csr_req   = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 12'hB02;
    csr_wdata = 32'd7;
    @(posedge clk);
    @(negedge clk);
    csr_req = 1'b0;
    check("exec.ready", 32'(csr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst.ready",  32'(csr_ready),  32'd1);
    check("async_rst.rvalid", 32'(csr_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst.ready",  32'(csr_ready),  32'd1);
    check("post_rst.rvalid", 32'(csr_rvalid), 32'd0);
    csr_xfer("c0_after_rst", 1'b0, 12'hB00, 32'd0, 32'd1, 1'b0);

    // clk_en low freezes C0 (3 here) for 5 cycles
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    csr_xfer("c0_clk_en_hold", 1'b0, 12'hB00, 32'd0, 32'd4, 1'b0);
    csr_xfer("c2_after_rst", 1'b0, 12'hB02, 32'd0, 32'd0, 1'b0);
    csr_xfer("inh_after_rst", 1'b0, 12'h320, 32'd0, 32'd0, 1'b0);
    csr_xfer("ev3_after_rst", 1'b0, 12'h323, 32'd0, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_ctrl.md
PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter PERF_CNT_LEN, default 64, width of every internal counter.
REQ-002 Parameter NUM_EVENTS, default 8, width of ev_vec.
REQ-003 clk  input  1  single core clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low; one clock, no other clock domain.
REQ-005 clk_en  input  1  global advance; when 0, FSM, counters and flags hold.
REQ-006 ev_retire  input  1  one instruction retired this cycle.
REQ-007 ev_vec  input  NUM_EVENTS  raw event pulses for HPM selection.
REQ-008 csr_req  input  1  CSR access request.
REQ-009 csr_we  input  1  1 = write, 0 = read.
REQ-010 csr_addr  input  12  CSR address.
REQ-011 csr_wdata  input  32  write data.
REQ-012 csr_ready  output  1  controller can accept a request.
REQ-013 csr_rvalid  output  1  response valid, one-cycle pulse.
REQ-014 csr_rdata  output  32  read data, valid with csr_rvalid.
REQ-015 csr_err  output  1  illegal access, valid with csr_rvalid.

Function
REQ-016 Four counters SHALL exist: C0 = mcycle, C2 = minstret, C3 = mhpmcounter3, C4 = mhpmcounter4, each PERF_CNT_LEN bits.
REQ-017 Address map SHALL be:
- 0xB00/0xB80 C0 lo/hi
- 0xB02/0xB82 C2 lo/hi
- 0xB03/0xB83 C3 lo/hi
- 0xB04/0xB84 C4 lo/hi
- 0x320 mcountinhibit; implemented bits 0, 2, 3, 4; other bits read 0 and ignore writes
- 0x323/0x324 mhpmevent3/4; bits [3:0] implemented, upper bits read 0
- 0x7C0 ovf; bits {4,3,2,0}; reads return flags; a write clears each flag whose wdata bit is 1 (W1C)
- 0xC00/0xC80 and 0xC02/0xC82 read-only mirrors of C0/C2
REQ-018 Increments, per clk_en cycle, while the inhibit bit is 0:
- C0 increments by 1 every cycle.
- C2 increments by 1 when ev_retire = 1.
- C3/C4 increment by 1 when mhpmevent value sel is 1..NUM_EVENTS and ev_vec[sel-1] = 1.
- sel = 0 or sel > NUM_EVENTS: no counting.
REQ-019 Counter arithmetic SHALL be modulo 2^PERF_CNT_LEN; an increment from all-ones to zero SHALL set the matching ovf bit (sticky).
REQ-020 FSM states SHALL be IDLE, EXEC, RESP:
- IDLE -> EXEC on csr_req & csr_ready & clk_en; request fields are latched on that edge.
- EXEC -> RESP unconditionally (clk_en permitting).
- RESP -> IDLE unconditionally.
REQ-021 csr_ready SHALL be 1 only in IDLE; csr_rvalid SHALL be 1 only in RESP; response latency SHALL be 2 enabled cycles after acceptance.
REQ-022 Reads SHALL sample the addressed value in EXEC; writes SHALL take effect at the end of EXEC.
REQ-023 A write to a lo half SHALL replace bits [31:0] only; a write to a hi half SHALL replace bits [63:32] only.
REQ-024 In the cycle a counter is written, the write SHALL win and that counter SHALL NOT increment.
REQ-025 If a W1C clear and a new overflow hit the same ovf bit in the same cycle, the set SHALL win.
REQ-026 Any of the following SHALL return csr_err = 1, csr_rdata = 0, with no state change:
- an unmapped address;
- a write to a 0xCxx mirror.
REQ-027 Accesses without error SHALL return csr_err = 0; a write response returns csr_rdata = 0.
REQ-028 csr_req while not IDLE SHALL be ignored; the requester holds it until csr_ready.

Reset
REQ-029 On rst_n low, asynchronously:
- all counters 0, mcountinhibit 0, mhpmevent 0, ovf 0;
- FSM in IDLE;
- csr_ready = 1, csr_rvalid = 0, csr_rdata = 0, csr_err = 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no partial write and no response.

Verification
REQ-031 Release reset, hold clk_en = 1 for 10 cycles, read 0xB00 -> rvalid 2 cycles after acceptance, rdata = 10 + cycles elapsed to EXEC.
REQ-032 Write 0x323 = 3, pulse ev_vec[2] 5 times, ev_vec[0] 4 times, read 0xB03 -> 5; set sel = 0 -> C3 frozen.
REQ-033 Write 0xB83 = 0xFFFFFFFF and 0xB03 = 0xFFFFFFFE, sel = 1, two ev_vec[0] pulses -> C3 = 0, read 0x7C0 bit3 = 1; write 0x7C0 = 0x8 -> reads 0.
REQ-034 Write 0x320 = 0x1 -> C0 holds; write 0xB00 = 0x55 with ev active -> reads 0x55 exactly (no increment in write cycle).
REQ-035 Write 0xC00 -> err = 1, C0 unchanged; read 0x7FF -> err = 1, rdata = 0.
REQ-036 Assert rst_n low during EXEC of write 0xB02 = 7 -> C2 = 0, no rvalid, ready = 1 after release.
